// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one data-memory port between CPU and external master.
// Optional build macro DBUS_FIXED_PRIORITY_EN makes the CPU win every tie.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int CNT_WIDTH       = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpuReq,
  input  logic                       cpuWr,
  input  logic [DATA_ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0]      cpuWrData,
  output logic [DATA_WIDTH-1:0]      cpuRdData,
  output logic                       cpuAck,
  output logic                       cpuStall,
  input  logic                       extReq,
  input  logic                       extWr,
  input  logic [DATA_ADDR_WIDTH-1:0] extAddr,
  input  logic [DATA_WIDTH-1:0]      extWrData,
  output logic [DATA_WIDTH-1:0]      extRdData,
  output logic                       extAck,
  output logic                       memReq,
  output logic                       memWr,
  output logic [DATA_ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0]      memWrData,
  input  logic [DATA_WIDTH-1:0]      memRdData,
  input  logic                       memAck,
  output logic                       timeoutErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  // owner/lastGrant encoding: 0 = CPU, 1 = EXT
  logic [1:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       last_q, last_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       wr_q, wr_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       terr_q, terr_d;
  logic                       pick_ext;
  logic                       busy, done;

  // Pick the winner among the requests seen in IDLE.
  always_comb begin
`ifdef DBUS_FIXED_PRIORITY_EN
    pick_ext = extReq & ~cpuReq;
`else
    pick_ext = extReq & (~cpuReq | ~last_q);
`endif
  end

  // Controller next-state and payload capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpuReq | extReq) begin
          owner_d = pick_ext;
          wr_d    = pick_ext ? extWr : cpuWr;
          addr_d  = pick_ext ? extAddr : cpuAddr;
          wdata_d = pick_ext ? extWrData : cpuWrData;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (memAck) begin
          rdata_d = memRdData;
          last_d  = owner_q;
          state_d = S_DONE;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          terr_d  = 1'b1;
          last_d  = owner_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and payload registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy       = (state_q == S_BUSY);
    done       = (state_q == S_DONE);
    memReq     = busy;
    memWr      = busy & wr_q;
    memAddr    = addr_q;
    memWrData  = wdata_q;
    cpuAck     = done & ~owner_q;
    extAck     = done & owner_q;
    cpuRdData  = cpuAck ? rdata_q : '0;
    extRdData  = extAck ? rdata_q : '0;
    cpuStall   = cpuReq & ~cpuAck;
    timeoutErr = terr_q;
  end

endmodule
